// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low glyphs (bit 0 = a ... bit 6 = g)
// and the special codes used on the BCD side of the display path.
package ssd_pkg;

  localparam logic [6:0] SSD_0     = 7'b1000000;
  localparam logic [6:0] SSD_1     = 7'b1111001;
  localparam logic [6:0] SSD_2     = 7'b0100100;
  localparam logic [6:0] SSD_3     = 7'b0110000;
  localparam logic [6:0] SSD_4     = 7'b0011001;
  localparam logic [6:0] SSD_5     = 7'b0010010;
  localparam logic [6:0] SSD_6     = 7'b0000010;
  localparam logic [6:0] SSD_7     = 7'b1111000;
  localparam logic [6:0] SSD_8     = 7'b0000000;
  localparam logic [6:0] SSD_9     = 7'b0010000;
  localparam logic [6:0] SSD_E     = 7'b0000110;
  localparam logic [6:0] SSD_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_OVR   = 4'hE;
  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/ssd2bcd.sv
// Combinational glyph decoder: active-low segment pattern -> BCD code.
// Unknown patterns decode to blank with err set.
module ssd2bcd
  import ssd_pkg::*;
(
  input  logic [6:0] hex,
  output logic [3:0] code,
  output logic       err
);

  // table lookup; anything not in the glyph set is flagged
  always_comb begin
    code = BCD_BLANK;
    err  = 1'b0;
    case (hex)
      SSD_0:     code = 4'd0;
      SSD_1:     code = 4'd1;
      SSD_2:     code = 4'd2;
      SSD_3:     code = 4'd3;
      SSD_4:     code = 4'd4;
      SSD_5:     code = 4'd5;
      SSD_6:     code = 4'd6;
      SSD_7:     code = 4'd7;
      SSD_8:     code = 4'd8;
      SSD_9:     code = 4'd9;
      SSD_E:     code = BCD_OVR;
      SSD_BLANK: code = BCD_BLANK;
      default:   err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_rx.sv
// Receive side of the multiplexed seven-segment bus. Synchronizes HEX/dig_en,
// waits for a glyph to be stable for STABLE_CYC samples, then decodes it into
// the strobed digit's register. Tracks full frames and strobe faults.
module ssd_scan_rx
  import ssd_pkg::*;
#(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         HEX,
  input  logic [N_DIG-1:0]   dig_en,
  output logic [4*N_DIG-1:0] bcd,
  output logic [N_DIG-1:0]   dig_err,
  output logic               upd,
  output logic               frame_done,
  output logic               scan_err
);

  localparam logic [7:0] STAB = 8'(STABLE_CYC);

  logic [6:0]       hex_s1, hex_s, hex_p;
  logic [N_DIG-1:0] en_s1, en_s, en_p;
  logic [7:0]       cnt;
  logic             done;
  logic [N_DIG-1:0] seen, seen_nxt;
  logic             s_onehot, s_multi, p_multi, s_chg, commit;
  logic [3:0]       dec_code;
  logic             dec_err;

  // two-flop synchronizers plus one delayed copy; the delayed copy (hex_p/en_p)
  // is the sample that cnt describes, so it is the one that gets committed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_s1 <= '0;
      hex_s  <= '0;
      hex_p  <= '0;
      en_s1  <= '0;
      en_s   <= '0;
      en_p   <= '0;
    end else begin
      hex_s1 <= HEX;
      hex_s  <= hex_s1;
      hex_p  <= hex_s;
      en_s1  <= dig_en;
      en_s   <= en_s1;
      en_p   <= en_s;
    end
  end

  // strobe classification and commit qualification
  always_comb begin
    s_onehot = $onehot(en_s);
    s_multi  = ($countones(en_s) > 1);
    p_multi  = ($countones(en_p) > 1);
    s_chg    = ({hex_s, en_s} != {hex_p, en_p});
    // cnt is only ever non-zero for a one-hot sample, so en_p is one-hot here
    commit   = !done && (cnt == STAB);
    seen_nxt = seen | en_p;
  end

  // stability counter; done blocks a second commit of the same stable value,
  // which matters when cnt saturates at STABLE_CYC=255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (!s_onehot) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (s_chg) begin
      cnt  <= 8'd1;
      done <= 1'b0;
    end else begin
      if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      if (commit) done <= 1'b1;
    end
  end

  ssd2bcd u_dec (
    .hex  (hex_p),
    .code (dec_code),
    .err  (dec_err)
  );

  // per-digit result registers, loaded only for the strobed digit on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd     <= {N_DIG{BCD_BLANK}};
      dig_err <= '0;
    end else if (commit) begin
      for (int i = 0; i < N_DIG; i++) begin
        if (en_p[i]) begin
          bcd[4*i +: 4] <= dec_code;
          dig_err[i]    <= dec_err;
        end
      end
    end
  end

  // event pulses and frame mask; the completing commit clears the mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd        <= 1'b0;
      frame_done <= 1'b0;
      scan_err   <= 1'b0;
      seen       <= '0;
    end else begin
      upd        <= commit;
      frame_done <= 1'b0;
      scan_err   <= s_multi && !p_multi;
      if (commit) begin
        if (&seen_nxt) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_rx.sv
// Randomized bench for ssd_scan_rx with a sample-history reference model:
// a commit is predicted from the raw input history (run of STABLE_CYC equal
// one-hot samples, offset by the synchronizer latency), not from RTL state.
module tb_ssd_scan_rx;

  localparam int N = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [6:0]     HEX;
  logic [N-1:0]   dig_en;
  logic [4*N-1:0] bcd;
  logic [N-1:0]   dig_err;
  logic           upd, frame_done, scan_err;

  ssd_scan_rx #(.N_DIG(N), .STABLE_CYC(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .HEX        (HEX),
    .dig_en     (dig_en),
    .bcd        (bcd),
    .dig_err    (dig_err),
    .upd        (upd),
    .frame_done (frame_done),
    .scan_err   (scan_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] glyph [12] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0000110, 7'b1111111};

  // reference decode: position in the glyph list gives the code
  task automatic ref_dec(input logic [6:0] h, output logic [3:0] c, output logic e);
    c = 4'hF;
    e = 1'b1;
    for (int i = 0; i < 10; i++) if (glyph[i] == h) begin c = 4'(i); e = 1'b0; end
    if (h == glyph[10]) begin c = 4'hE; e = 1'b0; end
    if (h == glyph[11]) begin c = 4'hF; e = 1'b0; end
  endtask

  function automatic int ones(input logic [N-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(v[i]);
    return n;
  endfunction

  // model state: input history sampled at each edge, plus expected registers
  logic [10:0]    hist[$];
  logic [4*N-1:0] m_bcd;
  logic [N-1:0]   m_err, m_seen;
  int upd_n, fd_n, se_n;

  function automatic logic [10:0] h(input int d);
    return hist[hist.size() - 1 - d];
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < S + 6; i++) hist.push_back('0);
    m_bcd  = '1;
    m_err  = '0;
    m_seen = '0;
  endtask

  // one clock: record sample, predict, check away from the edge
  task automatic step();
    logic       e_upd, e_fd, e_se, run, de;
    logic [3:0] dc;
    logic [10:0] v;
    @(posedge clk);
    hist.push_back({HEX, dig_en});
    if (hist.size() > 64) void'(hist.pop_front());
    e_upd = 1'b0;
    e_fd  = 1'b0;
    e_se  = (ones(h(2)[N-1:0]) > 1) && !(ones(h(3)[N-1:0]) > 1);
    v = h(3);
    run = (ones(v[N-1:0]) == 1) && (h(3 + S) != v);
    for (int d = 4; d < 3 + S; d++) if (h(d) != v) run = 1'b0;
    if (run) begin
      e_upd = 1'b1;
      ref_dec(v[10:4], dc, de);
      for (int i = 0; i < N; i++) if (v[i]) begin
        m_bcd[4*i +: 4] = dc;
        m_err[i]        = de;
        m_seen[i]       = 1'b1;
      end
      if (&m_seen) begin
        e_fd   = 1'b1;
        m_seen = '0;
      end
    end
    #1;
    chk("pulses", {29'd0, upd, frame_done, scan_err}, {29'd0, e_upd, e_fd, e_se});
    chk("bcd", 32'(bcd), 32'(m_bcd));
    chk("dig_err", 32'(dig_err), 32'(m_err));
    upd_n += int'(upd);
    fd_n  += int'(frame_done);
    se_n  += int'(scan_err);
  endtask

  task automatic hold(input logic [6:0] hx, input logic [N-1:0] en, input int n);
    HEX    = hx;
    dig_en = en;
    repeat (n) step();
  endtask

  task automatic flush();
    hold(7'h7F, '0, S + 4);
  endtask

  task automatic zero_cnt();
    upd_n = 0;
    fd_n  = 0;
    se_n  = 0;
  endtask

  // asynchronous reset applied between edges, checked before the next edge
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_bcd", 32'(bcd), {16'd0, 16'hFFFF});
    chk("rst_err", 32'(dig_err), 32'd0);
    chk("rst_pulses", {29'd0, upd, frame_done, scan_err}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    rst_n  = 1'b0;
    HEX    = 7'h7F;
    dig_en = '0;
    zero_cnt();
    model_clear();
    #2;
    do_reset();

    // basic capture: one upd, digit 1 = 2
    zero_cnt();
    hold(glyph[2], 4'b0010, 10);
    flush();
    chk("basic_upd", 32'(upd_n), 32'd1);
    chk("basic_nib", 32'(bcd[7:4]), 32'd2);

    // full frames
    do_reset();
    zero_cnt();
    for (int d = 0; d < 4; d++) hold(glyph[d + 1], 4'(1 << d), 8);
    flush();
    chk("frame_bcd", 32'(bcd), 32'h4321);
    chk("frame1_fd", 32'(fd_n), 32'd1);
    zero_cnt();
    for (int d = 0; d < 4; d++) hold(glyph[d + 1], 4'(1 << d), 8);
    flush();
    chk("frame2_fd", 32'(fd_n), 32'd1);

    // glitch rejection
    zero_cnt();
    hold(glyph[8], 4'b0001, 3);
    hold(glyph[5], 4'b0001, 5);
    flush();
    chk("glitch_upd", 32'(upd_n), 32'd1);
    chk("glitch_nib", 32'(bcd[3:0]), 32'd5);

    // decode edges on digit 2
    hold(glyph[10], 4'b0100, 8);
    hold(glyph[11], 4'b1000, 8);
    flush();
    chk("ovr_nib", 32'(bcd[11:8]), 32'hE);
    chk("blank_nib", 32'(bcd[15:12]), 32'hF);
    hold(7'b0101010, 4'b0100, 8);
    flush();
    chk("bad_err", 32'(dig_err[2]), 32'd1);
    hold(glyph[7], 4'b0100, 8);
    flush();
    chk("fix_err", 32'(dig_err[2]), 32'd0);
    chk("fix_nib", 32'(bcd[11:8]), 32'd7);

    // strobe faults
    zero_cnt();
    hold(glyph[3], 4'b0110, 10);
    flush();
    chk("multi_se", 32'(se_n), 32'd1);
    chk("multi_upd", 32'(upd_n), 32'd0);
    zero_cnt();
    hold(glyph[3], 4'b0000, 10);
    chk("zero_pulses", 32'(se_n + upd_n + fd_n), 32'd0);

    // random scanning, with a reset dropped in mid-stream
    for (int k = 0; k < 400; k++) begin
      logic [6:0]   hx;
      logic [N-1:0] en;
      int r;
      r  = int'($urandom_range(0, 99));
      hx = (r < 65) ? glyph[$urandom_range(0, 11)] : 7'($urandom);
      r  = int'($urandom_range(0, 99));
      if (r < 70)      en = 4'(1 << $urandom_range(0, N - 1));
      else if (r < 85) en = '0;
      else             en = 4'($urandom);
      hold(hx, en, int'($urandom_range(1, 9)));
      if (k == 200) do_reset();
    end
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
